// File: rtl/mem_lsu.sv
// Memory-access stage: turns RISC-V loads/stores into aligned bus word transactions and registers WB fields.
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module mem_lsu (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] inst_i,
    input  logic        mem_r_ena_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        hold_o,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] reg_w_data_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t      state;

    logic [2:0]  funct3;
    logic        access;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        misaligned;
    logic        unused_bits;

    logic        st_store;
    logic        st_misalign;
    logic [1:0]  st_a;
    logic [1:0]  st_size;
    logic        st_uns;
    logic        st_rd_ena;
    logic [4:0]  st_rd;
    logic [31:0] load_data;

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_B:    lane_be = 4'b0001 << a;
            SZ_H:    lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    lane_wdata = {4{d[7:0]}};
            SZ_H:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] a,
                                                input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_B:    extend_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    extend_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extend_load = d;
        endcase
    endfunction

    assign funct3 = inst_i[14:12];
    assign access = mem_r_ena_i | mem_w_ena_i;
    // A simultaneous read and write request is treated as the store.
    assign addr   = mem_w_ena_i ? mem_w_addr_i : mem_r_addr_i;
    assign size   = (funct3[1:0] == 2'b00) ? SZ_B :
                    (funct3[1:0] == 2'b01) ? SZ_H : SZ_W;
    assign unused_bits = ^{inst_i[31:15], inst_i[11:0]};

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= (state == IDLE) && access && misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // The stall is combinational so the pipeline freezes in the same cycle the access is seen.
    always_comb begin
        hold_o = 1'b0;
        case (state)
            IDLE:      hold_o = access;
            REQ, WAIT: hold_o = 1'b1;
            default:   hold_o = 1'b0;
        endcase
        if (!arst_n) hold_o = 1'b0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= 32'h0;
            bus_be_o     <= 4'h0;
            bus_wdata_o  <= 32'h0;
            reg_w_ena_o  <= 1'b0;
            reg_w_addr_o <= 5'h0;
            reg_w_data_o <= 32'h0;
            st_store     <= 1'b0;
            st_misalign  <= 1'b0;
            st_a         <= 2'h0;
            st_size      <= 2'h0;
            st_uns       <= 1'b0;
            st_rd_ena    <= 1'b0;
            st_rd        <= 5'h0;
            load_data    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        st_store    <= mem_w_ena_i;
                        st_misalign <= misaligned;
                        st_a        <= addr[1:0];
                        st_size     <= size;
                        st_uns      <= funct3[2];
                        st_rd_ena   <= reg_w_ena_i;
                        st_rd       <= reg_w_addr_i;
                        reg_w_ena_o <= 1'b0;
                        if (misaligned) begin
                            state <= DONE;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_w_ena_i;
                            bus_addr_o  <= {addr[31:2], 2'b00};
                            bus_be_o    <= lane_be(size, addr[1:0]);
                            bus_wdata_o <= lane_wdata(size, mem_w_data_i);
                            state       <= REQ;
                        end
                    end else begin
                        reg_w_ena_o  <= reg_w_ena_i && (reg_w_addr_i != 5'd0);
                        reg_w_addr_o <= reg_w_addr_i;
                        reg_w_data_o <= reg_w_data_i;
                    end
                end
                REQ: begin
                    reg_w_ena_o <= 1'b0;
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        if (st_store) begin
                            state <= DONE;
                        end else if (bus_rvalid_i) begin
                            load_data <= extend_load(bus_rdata_i, st_a, st_size, st_uns);
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    reg_w_ena_o <= 1'b0;
                    if (bus_rvalid_i) begin
                        load_data <= extend_load(bus_rdata_i, st_a, st_size, st_uns);
                        state     <= DONE;
                    end
                end
                default: begin
                    reg_w_ena_o  <= !st_store && !st_misalign && st_rd_ena && (st_rd != 5'd0);
                    reg_w_addr_o <= st_rd;
                    reg_w_data_o <= load_data;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
